// File: rtl/cvp_mem_arbiter.sv
// cvp_mem_arbiter: shares the CVP14 system-memory port between the core
// (requester 0) and the host loader/DMA engine (requester 1).
//   - registered req/gnt handshake, one mandatory IDLE turnaround cycle
//   - unlocked tenure limited to MAX_TENURE cycles while the other side waits
//   - lockx keeps the port for bursts (VLD/VST 16-word transfers)
// Configuration macro: CVP_ARB_ROUND_ROBIN_EN
//   defined   : contested grants from IDLE alternate via `owner`
//   undefined : requester 0 always wins contested grants
module cvp_mem_arbiter #(
    parameter int DW         = 16,
    parameter int AW         = 16,
    parameter int MAX_TENURE = 16
) (
    input  logic          Clk1,
    input  logic          Reset,
    input  logic          req0,
    input  logic          req1,
    input  logic          lock0,
    input  logic          lock1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic          rd0,
    input  logic          rd1,
    input  logic          wr0,
    input  logic          wr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    output logic          gnt0,
    output logic          gnt1,
    output logic [DW-1:0] rdata,
    output logic [AW-1:0] Addr,
    output logic          RD,
    output logic          WR,
    output logic [DW-1:0] DataOut,
    input  logic [DW-1:0] DataIn,
    output logic          busy,
    output logic          owner
);

    // Last tenure count an unlocked owner may reach before yielding.
    localparam logic [7:0] TEN_LAST = 8'(MAX_TENURE - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } state_t;

    state_t      r_state;
    logic        r_gnt0;
    logic        r_gnt1;
    logic        r_owner;
    logic [7:0]  r_tenure;

    logic        w_contest_pick1;
    logic        w_pick1;
    logic        w_own_req;
    logic        w_own_lock;
    logic        w_oth_req;
    logic        w_release;
    logic        w_preempt;

`ifdef CVP_ARB_ROUND_ROBIN_EN
    // Contested grant goes to whoever did not own the port last.
    assign w_contest_pick1 = ~r_owner;
`else
    // Fixed priority: requester 0 always wins a contested grant.
    assign w_contest_pick1 = 1'b0;
`endif

    // Requester 1 is granted when it is alone or wins the contest.
    assign w_pick1 = req1 & (~req0 | w_contest_pick1);

    // Select the current owner's controls and the other side's request.
    always_comb begin
        w_own_req  = 1'b0;
        w_own_lock = 1'b0;
        w_oth_req  = 1'b0;
        case (r_state)
            ST_OWN0: begin
                w_own_req  = req0;
                w_own_lock = lock0;
                w_oth_req  = req1;
            end
            ST_OWN1: begin
                w_own_req  = req1;
                w_own_lock = lock1;
                w_oth_req  = req0;
            end
            default: ;
        endcase
    end

    assign w_release = ~w_own_req;
    assign w_preempt = w_oth_req & ~w_own_lock & (r_tenure == TEN_LAST);

    // Ownership FSM with registered grants, owner index and tenure counter.
    always_ff @(posedge Clk1) begin
        if (Reset) begin
            r_state  <= ST_IDLE;
            r_gnt0   <= 1'b0;
            r_gnt1   <= 1'b0;
            r_owner  <= 1'b1;
            r_tenure <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_tenure <= '0;
                    if (req0 | req1) begin
                        if (w_pick1) begin
                            r_state <= ST_OWN1;
                            r_gnt1  <= 1'b1;
                            r_owner <= 1'b1;
                        end else begin
                            r_state <= ST_OWN0;
                            r_gnt0  <= 1'b1;
                            r_owner <= 1'b0;
                        end
                    end
                end
                ST_OWN0, ST_OWN1: begin
                    if (w_release | w_preempt) begin
                        // Always pass through IDLE: one-cycle bus turnaround.
                        r_state  <= ST_IDLE;
                        r_gnt0   <= 1'b0;
                        r_gnt1   <= 1'b0;
                        r_tenure <= '0;
                    end else if (!w_own_lock && (r_tenure != TEN_LAST)) begin
                        r_tenure <= r_tenure + 8'd1;
                    end
                end
                default: begin
                    r_state  <= ST_IDLE;
                    r_gnt0   <= 1'b0;
                    r_gnt1   <= 1'b0;
                    r_tenure <= '0;
                end
            endcase
        end
    end

    // Memory port mux: owner's request passes through, idle drives zeros.
    always_comb begin
        Addr    = '0;
        RD      = 1'b0;
        WR      = 1'b0;
        DataOut = '0;
        case (r_state)
            ST_OWN0: begin
                Addr    = addr0;
                RD      = rd0;
                WR      = wr0;
                DataOut = wdata0;
            end
            ST_OWN1: begin
                Addr    = addr1;
                RD      = rd1;
                WR      = wr1;
                DataOut = wdata1;
            end
            default: ;
        endcase
    end

    assign gnt0  = r_gnt0;
    assign gnt1  = r_gnt1;
    assign busy  = r_gnt0 | r_gnt1;
    assign owner = r_owner;
    assign rdata = DataIn;

endmodule

// File: tb/tb_cvp_mem_arbiter.sv
// tb_cvp_mem_arbiter: randomized + directed stimulus, reference model of the
// ownership rules, scoreboard queue drained by a negedge monitor.
module tb_cvp_mem_arbiter;

    localparam int DW = 16;
    localparam int AW = 16;
    localparam int MT = 4;

    logic          Clk1 = 1'b0;
    logic          Reset = 1'b1;
    logic          req0 = 1'b0, req1 = 1'b0, lock0 = 1'b0, lock1 = 1'b0;
    logic [AW-1:0] addr0 = '0, addr1 = '0;
    logic          rd0 = 1'b0, rd1 = 1'b0, wr0 = 1'b0, wr1 = 1'b0;
    logic [DW-1:0] wdata0 = '0, wdata1 = '0;
    logic [DW-1:0] DataIn = '0;
    logic          gnt0, gnt1, RD, WR, busy, owner;
    logic [DW-1:0] rdata, DataOut;
    logic [AW-1:0] Addr;

    cvp_mem_arbiter #(.DW(DW), .AW(AW), .MAX_TENURE(MT)) dut (
        .Clk1(Clk1), .Reset(Reset),
        .req0(req0), .req1(req1), .lock0(lock0), .lock1(lock1),
        .addr0(addr0), .addr1(addr1),
        .rd0(rd0), .rd1(rd1), .wr0(wr0), .wr1(wr1),
        .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .rdata(rdata),
        .Addr(Addr), .RD(RD), .WR(WR), .DataOut(DataOut), .DataIn(DataIn),
        .busy(busy), .owner(owner)
    );

    always #5 Clk1 = ~Clk1;

    typedef struct {
        logic          g0, g1, bsy, own, rd, wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] dout, rdat;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;

    // Reference model: who holds the port (-1 none), last owner, and the
    // number of unlocked cycles the holder has used so far.
    int   holder = -1;
    int   last   = 1;
    int   used   = 0;

    function automatic int choose();
        if (req0 && req1) begin
`ifdef CVP_ARB_ROUND_ROBIN_EN
            return (last == 0) ? 1 : 0;
`else
            return 0;
`endif
        end
        if (req0) return 0;
        if (req1) return 1;
        return -1;
    endfunction

    task automatic model_edge();
        logic mine, lk, other;
        int   w;
        if (Reset) begin
            holder = -1; last = 1; used = 0;
        end else if (holder < 0) begin
            w = choose();
            if (w >= 0) begin
                holder = w; last = w; used = 0;
            end
        end else begin
            mine  = (holder == 0) ? req0  : req1;
            lk    = (holder == 0) ? lock0 : lock1;
            other = (holder == 0) ? req1  : req0;
            if (!mine || (other && !lk && used >= MT - 1)) holder = -1;
            else if (!lk) used++;
        end
    endtask

    // Model process: advance on each edge, then predict the cycle's outputs
    // once the stimulus for that cycle has been applied.
    initial begin
        exp_t e;
        forever begin
            @(posedge Clk1);
            model_edge();
            #2;
            e.g0   = (holder == 0);
            e.g1   = (holder == 1);
            e.bsy  = (holder >= 0);
            e.own  = last[0];
            e.addr = (holder == 0) ? addr0  : (holder == 1) ? addr1  : '0;
            e.rd   = (holder == 0) ? rd0    : (holder == 1) ? rd1    : 1'b0;
            e.wr   = (holder == 0) ? wr0    : (holder == 1) ? wr1    : 1'b0;
            e.dout = (holder == 0) ? wdata0 : (holder == 1) ? wdata1 : '0;
            e.rdat = DataIn;
            exp_q.push_back(e);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, req);
        end
    endtask

    // Monitor: compare DUT outputs against the oldest prediction.
    initial begin
        exp_t e;
        forever begin
            @(negedge Clk1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("gnt0",    32'(gnt0),    32'(e.g0));
                chk("gnt1",    32'(gnt1),    32'(e.g1));
                chk("busy",    32'(busy),    32'(e.bsy));
                chk("owner",   32'(owner),   32'(e.own));
                chk("Addr",    32'(Addr),    32'(e.addr));
                chk("RD",      32'(RD),      32'(e.rd));
                chk("WR",      32'(WR),      32'(e.wr));
                chk("DataOut", 32'(DataOut), 32'(e.dout));
                chk("rdata",   32'(rdata),   32'(e.rdat));
            end
        end
    end

    task automatic nxt();
        @(posedge Clk1);
        #1;
        DataIn = DW'($urandom);
    endtask

    task automatic clr();
        req0 = 0; req1 = 0; lock0 = 0; lock1 = 0;
        rd0 = 0; rd1 = 0; wr0 = 0; wr1 = 0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    endtask

    task automatic idle(input int n);
        clr();
        repeat (n) nxt();
    endtask

    // Stimulus
    initial begin
        repeat (2) nxt();
        Reset = 0;
        idle(2);

        // Requester 0 alone reads 0x0010.
        req0 = 1; addr0 = 16'h0010; rd0 = 1;
        repeat (4) nxt();
        idle(2);

        // Contention from idle, then release of 0, then 1 served.
        req0 = 1; req1 = 1; addr0 = 16'h0020; addr1 = 16'h0030; rd0 = 1; rd1 = 1;
        repeat (3) nxt();
        req0 = 0; rd0 = 0;
        repeat (5) nxt();
        idle(2);
        req0 = 1; req1 = 1; rd0 = 1; wr1 = 1; addr0 = 16'h0040; addr1 = 16'h0050;
        repeat (3) nxt();
        idle(3);

        // Locked 16-word burst from requester 0 while 1 waits.
        req0 = 1; lock0 = 1; req1 = 1;
        nxt();
        for (int i = 0; i < 16; i++) begin
            wr0 = 1; addr0 = AW'(16'h0100 + i); wdata0 = DW'(16'hA000 + i);
            nxt();
        end
        req0 = 0; lock0 = 0; wr0 = 0;
        repeat (4) nxt();
        idle(2);

        // Unlocked tenure limit with both requesting.
        req0 = 1; req1 = 1; rd0 = 1; rd1 = 1; addr0 = 16'h0200; addr1 = 16'h0300;
        repeat (14) nxt();
        idle(2);

        // Lock dropped mid-tenure.
        req0 = 1; lock0 = 1; req1 = 1;
        repeat (8) nxt();
        lock0 = 0;
        repeat (6) nxt();
        idle(2);

        // Non-owner strobes have no effect.
        req0 = 1; rd0 = 0; addr0 = 16'h0011;
        nxt();
        wr1 = 1; wdata1 = 16'hBEEF; addr1 = 16'h0777;
        repeat (3) nxt();
        idle(2);

        // Reset in the middle of a locked burst by requester 1.
        req1 = 1; lock1 = 1;
        nxt();
        wr1 = 1; addr1 = 16'h0400; wdata1 = 16'h1234;
        repeat (3) nxt();
        Reset = 1;
        nxt();
        Reset = 0;
        repeat (3) nxt();
        idle(2);

        // Randomized traffic with sticky requests and locks.
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(7) == 0)  req0  = ~req0;
            if ($urandom_range(7) == 0)  req1  = ~req1;
            if ($urandom_range(15) == 0) lock0 = ~lock0;
            if ($urandom_range(15) == 0) lock1 = ~lock1;
            rd0 = 1'($urandom); wr0 = 1'($urandom);
            rd1 = 1'($urandom); wr1 = 1'($urandom);
            addr0 = AW'($urandom); addr1 = AW'($urandom);
            wdata0 = DW'($urandom); wdata1 = DW'($urandom);
            Reset = ($urandom_range(199) == 0);
            nxt();
        end
        Reset = 0;
        idle(3);

        @(negedge Clk1);
        #1;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain actual=%0d required=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
